// File: rtl/rank_order_encoder_if.sv
// Valid/ready event stream from the rank-order encoder toward the AER input controller.
interface rank_order_encoder_if #(
    parameter int IDX_W = 8
);
    logic [IDX_W+1:0] evt_data;
    logic             evt_valid;
    logic             evt_ready;

    modport master (output evt_data, output evt_valid, input evt_ready);
    modport slave  (input evt_data, input evt_valid, output evt_ready);
endinterface

// File: rtl/rank_order_encoder.sv
// Rank-order spike encoder: snapshots an image and streams pixel indices brightest-first,
// scanning LANES pixels per cycle, after a preamble of AER reset words.
module rank_order_encoder #(
    parameter  int IMAGE_SIZE     = 256,
    parameter  int PIXEL_BITS     = 8,
    parameter  int LANES          = 4,
    parameter  int PREAMBLE_WORDS = 2,
    localparam int IDX_W          = $clog2(IMAGE_SIZE),
    localparam int CNT_W          = $clog2(IMAGE_SIZE + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [IMAGE_SIZE*PIXEL_BITS-1:0] image_i,
    input  logic                             new_image_i,
    input  logic [PIXEL_BITS-1:0]            min_intensity_i,
    input  logic [CNT_W-1:0]                 max_events_i,
    input  logic                             abort_i,
    rank_order_encoder_if.master             evt,
    output logic [CNT_W-1:0]                 events_sent_o,
    output logic                             image_encoded_o,
    output logic                             encode_done_o
);
    localparam int NGROUPS = (IMAGE_SIZE + LANES - 1) / LANES;
    localparam int PAD     = NGROUPS * LANES;
    localparam int GRP_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam int PAD_W   = (PAD > 1) ? $clog2(PAD) : 1;
    localparam int LB_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PRE_W   = (PREAMBLE_WORDS > 0) ? $clog2(PREAMBLE_WORDS + 1) : 1;

    localparam logic [PIXEL_BITS-1:0] PIXEL_MAX  = '1;
    localparam logic [IDX_W+1:0]      RESET_WORD = {2'b01, {IDX_W{1'b1}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_SCAN = 2'd2;
    localparam logic [1:0] S_EMIT = 2'd3;

    logic [1:0]            state_q,   state_d;
    logic [PRE_W-1:0]      pre_cnt_q, pre_cnt_d;
    logic [GRP_W-1:0]      group_q,   group_d;
    logic [PIXEL_BITS-1:0] level_q,   level_d;
    logic [PIXEL_BITS-1:0] min_q,     min_d;
    logic [CNT_W-1:0]      max_q,     max_d;
    logic [LANES-1:0]      mask_q,    mask_d;
    logic [CNT_W-1:0]      sent_q,    sent_d;
    logic                  done_q,    done_d;

    logic [PIXEL_BITS-1:0] pix_q [IMAGE_SIZE];

    logic                  capture;
    logic                  handshake;
    logic                  advance;
    logic                  finish;
    logic [PAD_W-1:0]      base_idx;
    logic [PAD_W-1:0]      lane_idx;
    logic [LANES-1:0]      scan_mask;
    logic [LB_W-1:0]       low_bit;
    logic [IDX_W-1:0]      emit_idx;

    assign handshake = evt.evt_valid & evt.evt_ready;
    assign base_idx  = PAD_W'(int'(group_q) * LANES);

    // Lanes past the end of the image never match, so a ragged last group is safe.
    always_comb begin
        scan_mask = '0;
        lane_idx  = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_idx     = base_idx + PAD_W'(l);
            scan_mask[l] = (int'(lane_idx) < IMAGE_SIZE) &&
                           (pix_q[lane_idx[IDX_W-1:0]] == level_q);
        end
    end

    always_comb begin
        low_bit = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (mask_q[l]) low_bit = LB_W'(l);
        end
        emit_idx = IDX_W'(int'(base_idx) + int'(low_bit));
    end

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        group_d   = group_q;
        level_d   = level_q;
        min_d     = min_q;
        max_d     = max_q;
        mask_d    = mask_q;
        sent_d    = sent_q;
        done_d    = 1'b0;
        capture   = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (new_image_i) begin
                    capture   = 1'b1;
                    min_d     = min_intensity_i;
                    max_d     = max_events_i;
                    level_d   = PIXEL_MAX;
                    group_d   = '0;
                    sent_d    = '0;
                    pre_cnt_d = '0;
                    state_d   = (PREAMBLE_WORDS == 0) ? S_SCAN : S_PRE;
                end
            end
            S_PRE: begin
                if (handshake) begin
                    if (pre_cnt_q == PRE_W'(PREAMBLE_WORDS - 1)) state_d = S_SCAN;
                    else pre_cnt_d = pre_cnt_q + PRE_W'(1);
                end
            end
            S_SCAN: begin
                if (|scan_mask) begin
                    mask_d  = scan_mask;
                    state_d = S_EMIT;
                end else begin
                    advance = 1'b1;
                end
            end
            default: begin
                if (handshake) begin
                    sent_d = sent_q + CNT_W'(1);
                    mask_d = mask_q & (mask_q - LANES'(1));
                    if ((max_q != '0) && (sent_d == max_q)) finish = 1'b1;
                    else if (mask_d == '0) advance = 1'b1;
                end
            end
        endcase

        // Moving on to the next group or level costs no extra cycle.
        if (advance) begin
            if (group_q != GRP_W'(NGROUPS - 1)) begin
                group_d = group_q + GRP_W'(1);
                state_d = S_SCAN;
            end else if (level_q == min_q) begin
                finish = 1'b1;
            end else begin
                group_d = '0;
                level_d = level_q - PIXEL_BITS'(1);
                state_d = S_SCAN;
            end
        end

        if (finish) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
        end

        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pre_cnt_q <= '0;
            group_q   <= '0;
            level_q   <= '0;
            min_q     <= '0;
            max_q     <= '0;
            mask_q    <= '0;
            sent_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            group_q   <= group_d;
            level_q   <= level_d;
            min_q     <= min_d;
            max_q     <= max_d;
            mask_q    <= mask_d;
            sent_q    <= sent_d;
            done_q    <= done_d;
        end
    end

    // Image snapshot: plain data storage, contents irrelevant until the next capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < IMAGE_SIZE; i++) begin
                pix_q[i] <= image_i[i*PIXEL_BITS +: PIXEL_BITS];
            end
        end
    end

    assign evt.evt_valid   = (state_q == S_PRE) || (state_q == S_EMIT);
    assign evt.evt_data    = (state_q == S_PRE)  ? RESET_WORD :
                             (state_q == S_EMIT) ? {2'b00, emit_idx} : '0;
    assign events_sent_o   = sent_q;
    assign image_encoded_o = (state_q == S_IDLE);
    assign encode_done_o   = done_q;
endmodule

// File: tb/tb_rank_order_encoder.sv
// Bench for rank_order_encoder: spec vector table, randomized images against a
// level-sweep reference model, abort/reset sequences and a ragged-lane instance.
module tb_rank_order_encoder;
    localparam int N      = 8;
    localparam int PB     = 8;
    localparam int IDX_W  = 3;
    localparam int CNT_W  = 4;
    localparam int BUDGET = 2000;
    localparam logic [IDX_W+1:0] RESET_WORD = {2'b01, 3'b111};

    logic clk = 1'b0;
    logic rst;
    logic [N*PB-1:0] image;
    logic new_a, new_b, abort_a, abort_b, ready_a, ready_b;
    logic [PB-1:0] min_in;
    logic [CNT_W-1:0] max_in;
    logic [CNT_W-1:0] sent_a, sent_b;
    logic enc_a, enc_b, done_a, done_b;

    rank_order_encoder_if #(.IDX_W(IDX_W)) ifa ();
    rank_order_encoder_if #(.IDX_W(IDX_W)) ifb ();
    assign ifa.evt_ready = ready_a;
    assign ifb.evt_ready = ready_b;

    rank_order_encoder #(.IMAGE_SIZE(N), .PIXEL_BITS(PB), .LANES(4), .PREAMBLE_WORDS(2)) dut_a (
        .clk(clk), .rst(rst), .image_i(image), .new_image_i(new_a),
        .min_intensity_i(min_in), .max_events_i(max_in), .abort_i(abort_a),
        .evt(ifa), .events_sent_o(sent_a), .image_encoded_o(enc_a), .encode_done_o(done_a));

    rank_order_encoder #(.IMAGE_SIZE(N), .PIXEL_BITS(PB), .LANES(3), .PREAMBLE_WORDS(0)) dut_b (
        .clk(clk), .rst(rst), .image_i(image), .new_image_i(new_b),
        .min_intensity_i(min_in), .max_events_i(max_in), .abort_i(abort_b),
        .evt(ifb), .events_sent_o(sent_b), .image_encoded_o(enc_b), .encode_done_o(done_b));

    always #5 clk = ~clk;

    typedef struct {
        int min_v; int max_v; bit rnd; int abort_at; bit noise;
        int exp_sent; int exp_done;
    } vec_t;

    vec_t tbl [5];
    int spec_seq [8] = '{1, 2, 5, 4, 0, 7, 6, 3};
    int pix [N];
    logic [IDX_W+1:0] got [$];
    logic [IDX_W+1:0] exp_q [$];
    int checks = 0, errors = 0;
    int done_cnt, stall_bad, first_vld, exp_sent;
    bit timed_out;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [N*PB-1:0] pack();
        logic [N*PB-1:0] v;
        for (int i = 0; i < N; i++) v[i*PB +: PB] = PB'(pix[i]);
        return v;
    endfunction

    // Reference: sweep levels top-down, indices bottom-up, stop at the cap.
    task automatic model(input int min_v, input int max_v);
        exp_q.delete();
        exp_sent = 0;
        repeat (2) exp_q.push_back(RESET_WORD);
        for (int lev = 255; lev >= min_v; lev--)
            for (int i = 0; i < N; i++)
                if (pix[i] == lev && (max_v == 0 || exp_sent < max_v)) begin
                    exp_q.push_back({2'b00, 3'(i)});
                    exp_sent++;
                end
    endtask

    task automatic compare_stream(input string tag);
        int nd = 0;
        for (int k = 0; k < got.size() && k < exp_q.size(); k++)
            if (got[k] !== exp_q[k]) nd++;
        check({tag, "_len"}, got.size(), exp_q.size());
        check({tag, "_order"}, nd, 0);
    endtask

    task automatic encode_a(input int min_v, input int max_v, input bit rnd,
                            input int abort_at, input bit noise);
        int cyc, npix;
        bit prev_stall, aborted;
        logic [IDX_W+1:0] prev_data;
        got.delete();
        done_cnt = 0; stall_bad = 0; first_vld = -1; timed_out = 0;
        @(negedge clk);
        image = pack(); min_in = PB'(min_v); max_in = CNT_W'(max_v);
        new_a = 1'b1; ready_a = 1'b1;
        @(negedge clk);
        new_a = 1'b0; cyc = 1; npix = 0; prev_stall = 0; aborted = 0; prev_data = '0;
        while (1) begin
            if (cyc > BUDGET) begin timed_out = 1; break; end
            done_cnt += int'(done_a);
            if (enc_a) break;
            ready_a = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            new_a = noise && (cyc % 7 == 3);
            if (prev_stall && (!ifa.evt_valid || ifa.evt_data !== prev_data)) stall_bad++;
            if (ifa.evt_valid && first_vld < 0) first_vld = cyc;
            if (ifa.evt_valid && ready_a) begin
                got.push_back(ifa.evt_data);
                if (ifa.evt_data[IDX_W+1:IDX_W] == 2'b00) npix++;
                if (abort_at != 0 && npix == abort_at) begin abort_a = 1'b1; aborted = 1; end
            end
            prev_stall = ifa.evt_valid && !ready_a;
            prev_data = ifa.evt_data;
            @(negedge clk);
            cyc++;
            if (aborted) begin
                new_a = 1'b0; abort_a = 1'b0;
                done_cnt += int'(done_a);
                check("abort_idle", int'(enc_a), 1);
                check("abort_valid", int'(ifa.evt_valid), 0);
                break;
            end
        end
        new_a = 1'b0; ready_a = 1'b1;
        repeat (3) begin @(negedge clk); done_cnt += int'(done_a); end
    endtask

    task automatic post_checks(input string tag, input int req_sent, input int req_done);
        check({tag, "_sent"}, int'(sent_a), req_sent);
        check({tag, "_done"}, done_cnt, req_done);
        check({tag, "_stall"}, stall_bad, 0);
        check({tag, "_timeout"}, int'(timed_out), 0);
        check({tag, "_latency"}, first_vld, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, mn, mx;
        rst = 1'b1; image = '0; new_a = 0; new_b = 0; abort_a = 0; abort_b = 0;
        ready_a = 1'b1; ready_b = 1'b1; min_in = '0; max_in = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", int'(ifa.evt_valid), 0);
        check("rst_data", int'(ifa.evt_data), 0);
        check("rst_sent", int'(sent_a), 0);
        check("rst_encoded", int'(enc_a), 1);
        check("rst_done", int'(done_a), 0);
        check("rst_encoded_b", int'(enc_b), 1);
        rst = 1'b0;
        @(negedge clk);

        tbl[0] = '{0, 0, 0, 0, 0, 8, 1};
        tbl[1] = '{5, 0, 0, 0, 0, 4, 1};
        tbl[2] = '{0, 2, 0, 0, 0, 2, 1};
        tbl[3] = '{0, 0, 1, 0, 0, 8, 1};
        tbl[4] = '{0, 0, 0, 3, 1, 3, 0};
        pix = '{3, 7, 7, 0, 5, 7, 1, 2};
        for (int k = 0; k < 5; k++) begin
            exp_q.delete();
            repeat (2) exp_q.push_back(RESET_WORD);
            for (int e = 0; e < tbl[k].exp_sent; e++) exp_q.push_back({2'b00, 3'(spec_seq[e])});
            encode_a(tbl[k].min_v, tbl[k].max_v, tbl[k].rnd, tbl[k].abort_at, tbl[k].noise);
            compare_stream($sformatf("vec%0d", k));
            post_checks($sformatf("vec%0d", k), tbl[k].exp_sent, tbl[k].exp_done);
        end

        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < N; i++)
                pix[i] = (r % 2 == 1) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3)) * 85;
            mn = (r % 3 == 0) ? 0 : int'($urandom_range(0, 255));
            mx = int'($urandom_range(0, 9));
            model(mn, mx);
            encode_a(mn, mx, 1'b1, 0, 1'b0);
            compare_stream($sformatf("rand%0d", r));
            post_checks($sformatf("rand%0d", r), exp_sent, 1);
        end

        // Asynchronous reset while events are streaming.
        for (int i = 0; i < N; i++) pix[i] = 255;
        image = pack(); min_in = '0; max_in = '0;
        new_a = 1'b1;
        @(negedge clk);
        new_a = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", int'(ifa.evt_valid), 0);
        check("midrst_encoded", int'(enc_a), 1);
        check("midrst_sent", int'(sent_a), 0);
        check("midrst_done", int'(done_a), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Ragged lanes, no preamble, every pixel at level 0.
        for (int i = 0; i < N; i++) pix[i] = 0;
        image = pack(); min_in = '0; max_in = '0;
        exp_q.delete();
        for (int i = 0; i < N; i++) exp_q.push_back({2'b00, 3'(i)});
        got.delete(); done_cnt = 0; first_vld = -1;
        new_b = 1'b1;
        @(negedge clk);
        new_b = 1'b0;
        cyc = 1;
        while (!enc_b && cyc < BUDGET) begin
            done_cnt += int'(done_b);
            if (ifb.evt_valid && first_vld < 0) first_vld = cyc;
            if (ifb.evt_valid && ready_b) got.push_back(ifb.evt_data);
            @(negedge clk);
            cyc++;
        end
        done_cnt += int'(done_b);
        check("lanes3_timeout", int'(cyc < BUDGET), 1);
        compare_stream("lanes3");
        check("lanes3_first", first_vld, 767);
        check("lanes3_sent", int'(sent_b), 8);
        check("lanes3_done", done_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
